control_sequencer: RTL and testbench

Parametrised instruction sequencer for the 16-bit CPU. It latches an instruction on a `run` request and steps through a multi-cycle state machine. In each step it drives the datapath control strobes and one-hot register enables, then signals `done`. It replaces the separate step-counter plus state-decode arrangement. It supports a configurable register-file size, adds branch-if-zero and add-immediate operations, and reports illegal encodings.

---
 rtl/control_sequencer.sv | 134 +++++++++++++
 tb/tb_control_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit CPU: latches an instruction on run,
// then steps T1..T3 driving ALU/PC strobes and one-hot register enables.
module control_sequencer #(
  parameter int NREGS  = 8,
  parameter bit EXT_EN = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [15:0]      instr_in,
  input  logic             zero,
  output logic [NREGS-1:0] rin,
  output logic [NREGS-1:0] rout,
  output logic             gin,
  output logic             gout,
  output logic             ain,
  output logic             addsub,
  output logic             xorctrl,
  output logic             pcin,
  output logic             pcout,
  output logic             ctrl_out,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_ERR} state_t;

  localparam logic [3:0] OP_LOAD = 4'd0, OP_MOVE = 4'd1, OP_LDPC = 4'd2, OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4, OP_ADD  = 4'd5, OP_XOR  = 4'd6, OP_BZ     = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  op;
  logic [NREGS-1:0] rx_oh, ry_oh;
  logic        unused_ir_bits;

  function automatic logic is_legal(input logic [15:0] ins);
    logic [3:0] opc;
    logic       ok;
    opc = ins[15:12];
    ok  = (opc <= OP_ADDI);
    if ((opc == OP_BZ || opc == OP_ADDI) && !EXT_EN) ok = 1'b0;
    if ({1'b0, ins[11:8]} >= 5'(NREGS)) ok = 1'b0;
    // ry is only a source operand for the register-register forms
    if ((opc == OP_MOVE || opc == OP_SUB || opc == OP_ADD || opc == OP_XOR) &&
        ({1'b0, ins[7:4]} >= 5'(NREGS))) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [NREGS-1:0] onehot(input logic [3:0] idx);
    logic [NREGS-1:0] oh;
    for (int i = 0; i < NREGS; i++) oh[i] = (idx == 4'(i));
    return oh;
  endfunction

  assign op             = ir_q[15:12];
  assign rx_oh          = onehot(ir_q[11:8]);
  assign ry_oh          = onehot(ir_q[7:4]);
  assign unused_ir_bits = ^ir_q[3:0];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    rin      = '0;
    rout     = '0;
    gin      = 1'b0;
    gout     = 1'b0;
    ain      = 1'b0;
    addsub   = 1'b0;
    xorctrl  = 1'b0;
    pcin     = 1'b0;
    pcout    = 1'b0;
    ctrl_out = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          ir_d    = instr_in;
          state_d = is_legal(instr_in) ? S_T1 : S_ERR;
        end
      end
      S_T1: begin
        busy = 1'b1;
        case (op)
          OP_LOAD:   begin ctrl_out = 1'b1; rin = rx_oh; done = 1'b1; end
          OP_MOVE:   begin rout = ry_oh; rin = rx_oh; done = 1'b1; end
          OP_LDPC:   begin pcout = 1'b1; rin = rx_oh; done = 1'b1; end
          OP_BRANCH: begin rout = rx_oh; pcin = 1'b1; done = 1'b1; end
          OP_BZ:     begin rout = rx_oh; pcin = zero; done = 1'b1; end
          default:   begin rout = rx_oh; ain = 1'b1; end
        endcase
        state_d = done ? S_IDLE : S_T2;
      end
      S_T2: begin
        busy = 1'b1;
        gin  = 1'b1;
        if (op == OP_ADDI) ctrl_out = 1'b1;
        else               rout     = ry_oh;
        addsub  = (op == OP_SUB);
        xorctrl = (op == OP_XOR);
        state_d = S_T3;
      end
      S_T3: begin
        busy    = 1'b1;
        gout    = 1'b1;
        rin     = rx_oh;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised self-checking bench for control_sequencer: two instances (8 regs with extensions,
// 4 regs without) run the same stream against a step-table reference model.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic gin, gout, ain, addsub, xorctrl, pcin, pcout, ctrl_out, busy, done, illegal;
  } obs_t;

  logic        clock = 1'b0;
  logic        resetn, run, zero;
  logic [15:0] instr_in;

  logic [7:0] rin1, rout1;
  logic gin1, gout1, ain1, addsub1, xorctrl1, pcin1, pcout1, ctrl_out1, busy1, done1, illegal1;
  logic [3:0] rin2, rout2;
  logic gin2, gout2, ain2, addsub2, xorctrl2, pcin2, pcout2, ctrl_out2, busy2, done2, illegal2;

  obs_t o1, o2;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  control_sequencer #(.NREGS(8), .EXT_EN(1'b1)) dut (
    .clock(clock), .resetn(resetn), .run(run), .instr_in(instr_in), .zero(zero),
    .rin(rin1), .rout(rout1), .gin(gin1), .gout(gout1), .ain(ain1), .addsub(addsub1),
    .xorctrl(xorctrl1), .pcin(pcin1), .pcout(pcout1), .ctrl_out(ctrl_out1),
    .busy(busy1), .done(done1), .illegal(illegal1));

  control_sequencer #(.NREGS(4), .EXT_EN(1'b0)) dut_small (
    .clock(clock), .resetn(resetn), .run(run), .instr_in(instr_in), .zero(zero),
    .rin(rin2), .rout(rout2), .gin(gin2), .gout(gout2), .ain(ain2), .addsub(addsub2),
    .xorctrl(xorctrl2), .pcin(pcin2), .pcout(pcout2), .ctrl_out(ctrl_out2),
    .busy(busy2), .done(done2), .illegal(illegal2));

  assign o1 = {16'(rin1), 16'(rout1), gin1, gout1, ain1, addsub1, xorctrl1, pcin1, pcout1,
               ctrl_out1, busy1, done1, illegal1};
  assign o2 = {16'(rin2), 16'(rout2), gin2, gout2, ain2, addsub2, xorctrl2, pcin2, pcout2,
               ctrl_out2, busy2, done2, illegal2};

  // Reference model: instruction table written straight from the opcode descriptions.
  function automatic bit ref_legal(input logic [15:0] ins, input int nregs, input bit ext);
    int op, rx, ry;
    op = int'(ins[15:12]); rx = int'(ins[11:8]); ry = int'(ins[7:4]);
    if (op > 8) return 0;
    if ((op == 7 || op == 8) && !ext) return 0;
    if (rx >= nregs) return 0;
    if ((op == 1 || op == 4 || op == 5 || op == 6) && ry >= nregs) return 0;
    return 1;
  endfunction

  function automatic int ref_steps(input logic [15:0] ins, input int nregs, input bit ext);
    int op;
    op = int'(ins[15:12]);
    if (!ref_legal(ins, nregs, ext)) return 1;
    if (op == 4 || op == 5 || op == 6 || op == 8) return 3;
    return 1;
  endfunction

  function automatic obs_t ref_step(input logic [15:0] ins, input logic z, input int nregs,
                                    input bit ext, input int k);
    obs_t e;
    int op;
    logic [15:0] rxo, ryo;
    e = '0;
    op  = int'(ins[15:12]);
    rxo = 16'd1 << ins[11:8];
    ryo = 16'd1 << ins[7:4];
    e.busy = 1'b1;
    e.done = (k == ref_steps(ins, nregs, ext) - 1);
    if (!ref_legal(ins, nregs, ext)) begin
      e.illegal = 1'b1;
      return e;
    end
    case (op)
      0: begin e.ctrl_out = 1'b1; e.rin = rxo; end
      1: begin e.rout = ryo; e.rin = rxo; end
      2: begin e.pcout = 1'b1; e.rin = rxo; end
      3: begin e.rout = rxo; e.pcin = 1'b1; end
      7: begin e.rout = rxo; e.pcin = z; end
      default: begin
        if (k == 0) begin
          e.rout = rxo; e.ain = 1'b1;
        end else if (k == 1) begin
          e.gin = 1'b1;
          if (op == 8) e.ctrl_out = 1'b1; else e.rout = ryo;
          e.addsub  = (op == 4);
          e.xorctrl = (op == 6);
        end else begin
          e.gout = 1'b1; e.rin = rxo;
        end
      end
    endcase
    return e;
  endfunction

  // Called #1 after an edge while both instances are idle; accepts at the next edge and
  // checks every following cycle up to and including the return to IDLE.
  task automatic exec(input logic [15:0] ins, input logic z, input bit noisy,
                      input bit nrand, input logic [15:0] nins);
    int n1, n2, mx, mn;
    obs_t e1, e2;
    n1 = ref_steps(ins, 8, 1'b1);
    n2 = ref_steps(ins, 4, 1'b0);
    mx = (n1 > n2) ? n1 : n2;
    mn = (n1 < n2) ? n1 : n2;
    run = 1'b1; instr_in = ins; zero = z;
    @(posedge clock); #1;
    run = 1'b0; instr_in = 16'($urandom);
    for (int k = 0; k <= mx; k++) begin
      e1 = (k < n1) ? ref_step(ins, z, 8, 1'b1, k) : '0;
      e2 = (k < n2) ? ref_step(ins, z, 4, 1'b0, k) : '0;
      checks++;
      if (o1 !== e1) begin
        failures++;
        $display("FAIL exec_n8 ins=%h step=%0d actual=%h required=%h", ins, k, o1, e1);
      end
      checks++;
      if (o2 !== e2) begin
        failures++;
        $display("FAIL exec_n4 ins=%h step=%0d actual=%h required=%h", ins, k, o2, e2);
      end
      if (noisy && k < mn - 1) begin
        run = 1'b1; instr_in = nrand ? 16'($urandom) : nins;
      end else begin
        run = 1'b0;
      end
      if (k < mx) begin
        @(posedge clock); #1;
      end
    end
    run = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; run = 1'b0; zero = 1'b0; instr_in = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock); #1;
      checks++;
      if (o1 !== '0 || o2 !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d actual=%h/%h required=0", c, o1, o2);
      end
    end
    resetn = 1'b1;
    exec(16'h0300, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_alu;
    exec(16'h5120, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h4120, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h6120, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h8230, 1'b1, 1'b0, 1'b0, 16'h0);
    exec(16'h1320, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h2700, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h3200, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_bz;
    exec(16'h7500, 1'b1, 1'b0, 1'b0, 16'h0);
    exec(16'h7500, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h7200, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_illegal;
    exec(16'hA000, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h1090, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h8100, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'hF123, 1'b0, 1'b0, 1'b0, 16'h0);
    exec(16'h0800, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_run_while_busy;
    exec(16'h4120, 1'b0, 1'b1, 1'b0, 16'h0100);
    exec(16'h5310, 1'b0, 1'b1, 1'b1, 16'h0);
  endtask

  task automatic test_reset_mid;
    obs_t e;
    run = 1'b1; instr_in = 16'h5120;
    @(posedge clock); #1;
    run = 1'b0;
    e = ref_step(16'h5120, 1'b0, 8, 1'b1, 0);
    checks++;
    if (o1 !== e) begin
      failures++;
      $display("FAIL reset_mid_t1 actual=%h required=%h", o1, e);
    end
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (o1 !== '0 || o2 !== '0) begin
        failures++;
        $display("FAIL reset_mid_idle cycle=%0d actual=%h/%h required=0", c, o1, o2);
      end
      if (c == 0) begin
        @(posedge clock); #1;
      end
    end
    exec(16'h0300, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_random;
    logic [15:0] ins;
    for (int i = 0; i < 150; i++) begin
      ins = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 9)),
             4'($urandom_range(0, 9)), 4'($urandom)};
      exec(ins, 1'($urandom), 1'($urandom), 1'b1, 16'h0);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_bz;
    test_illegal;
    test_run_while_busy;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
